// File: rtl/synth_pkg.sv
// ============================================================================
// synth_pkg : shared envelope state encoding and width constants
// Rev 1.0
// ============================================================================
`default_nettype none

package synth_pkg;
  localparam int          ENV_W_DEF = 16;
  localparam logic [15:0] ENV_MAX   = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ATTACK  = 3'd1,
    S_DECAY   = 3'd2,
    S_SUSTAIN = 3'd3,
    S_RELEASE = 3'd4
  } adsr_state_e;
endpackage

`default_nettype wire

// File: rtl/env_tick.sv
// ============================================================================
// env_tick : free-running prescaler, pulses tick once every TICK_DIV clocks
// Rev 1.0
// ============================================================================
`default_nettype none

module env_tick #(
  parameter int TICK_DIV = 1000
) (
  input  logic CLK,
  input  logic RESET,
  output logic tick
);
  localparam int c_cnt_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(TICK_DIV - 1);

  logic [c_cnt_w-1:0] r_cnt;

  always_ff @(posedge CLK) begin
    if (RESET)                r_cnt <= '0;
    else if (r_cnt == c_last) r_cnt <= '0;
    else                      r_cnt <= r_cnt + 1'b1;
  end

  assign tick = (r_cnt == c_last);
endmodule

`default_nettype wire

// File: rtl/adsr_vca.sv
// ============================================================================
// adsr_vca : ADSR envelope generator plus VCA scaling of the form_wave output
// Rev 1.0
// ============================================================================
`default_nettype none

module adsr_vca
  import synth_pkg::*;
#(
  parameter int TICK_DIV = 1000,
  parameter int ENV_W    = ENV_W_DEF
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [31:0]      WAVE,
  input  logic             GATE,
  input  logic [ENV_W-1:0] ATTACK_STEP,
  input  logic [ENV_W-1:0] DECAY_STEP,
  input  logic [ENV_W-1:0] SUSTAIN,
  input  logic [ENV_W-1:0] RELEASE_STEP,
  output logic [ENV_W-1:0] OUT,
  output logic [ENV_W-1:0] ENV,
  output logic             ACTIVE,
  output logic [2:0]       STATE
);
  localparam logic [ENV_W-1:0] c_env_max = {ENV_W{1'b1}};

  adsr_state_e              r_state, w_state_nxt;
  logic [ENV_W-1:0]         r_env, w_env_nxt;
  logic [ENV_W-1:0]         r_out;
  logic                     r_gate_d;
  logic                     w_tick, w_rise, w_fall;
  logic [ENV_W:0]           w_sum;
  logic signed [ENV_W:0]    w_diff;
  logic [2*ENV_W-1:0]       w_prod;
  logic                     w_unused;

  env_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .CLK   (CLK),
    .RESET (RESET),
    .tick  (w_tick)
  );

  assign w_rise   = GATE & ~r_gate_d;
  assign w_fall   = ~GATE & r_gate_d;
  assign w_sum    = {1'b0, r_env} + {1'b0, ATTACK_STEP};
  assign w_diff   = $signed({1'b0, r_env}) - $signed({1'b0, DECAY_STEP});
  assign w_prod   = (2*ENV_W)'(WAVE[31:16]) * (2*ENV_W)'(r_env);
  assign w_unused = ^WAVE[15:0];

  // Edges outrank ticks: a retrigger or release swallows any step due this cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_env_nxt   = r_env;
    if (w_rise) begin
      w_state_nxt = S_ATTACK;
    end else if (w_fall && (r_state == S_ATTACK || r_state == S_DECAY ||
                            r_state == S_SUSTAIN)) begin
      w_state_nxt = S_RELEASE;
    end else begin
      case (r_state)
        S_ATTACK: if (w_tick) begin
          if (w_sum >= {1'b0, c_env_max}) begin
            w_env_nxt   = c_env_max;
            w_state_nxt = S_DECAY;
          end else begin
            w_env_nxt = w_sum[ENV_W-1:0];
          end
        end
        S_DECAY: if (w_tick) begin
          if (w_diff <= $signed({1'b0, SUSTAIN})) begin
            w_env_nxt   = SUSTAIN;
            w_state_nxt = S_SUSTAIN;
          end else begin
            w_env_nxt = w_diff[ENV_W-1:0];
          end
        end
        S_SUSTAIN: w_env_nxt = SUSTAIN;
        S_RELEASE: if (w_tick) begin
          if (r_env <= RELEASE_STEP) begin
            w_env_nxt   = '0;
            w_state_nxt = S_IDLE;
          end else begin
            w_env_nxt = r_env - RELEASE_STEP;
          end
        end
        default: begin
          w_env_nxt   = '0;
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state  <= S_IDLE;
      r_env    <= '0;
      r_out    <= '0;
      r_gate_d <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_env    <= w_env_nxt;
      r_out    <= w_prod[2*ENV_W-1:ENV_W];
      r_gate_d <= GATE;
    end
  end

  assign OUT    = r_out;
  assign ENV    = r_env;
  assign STATE  = r_state;
  assign ACTIVE = (r_state != S_IDLE);
endmodule

`default_nettype wire

// File: tb/tb_adsr_vca.sv
// ============================================================================
// tb_adsr_vca : directed plus randomized checks against a cycle reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_adsr_vca;
  localparam int TD = 4;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] WAVE = '0;
  logic        GATE = 1'b0;
  logic [15:0] ATTACK_STEP = '0, DECAY_STEP = '0, SUSTAIN = '0, RELEASE_STEP = '0;
  logic [15:0] OUT, ENV;
  logic        ACTIVE;
  logic [2:0]  STATE;

  int n_tot = 0;
  int n_bad = 0;

  // reference model state
  longint m_env = 0, m_out = 0;
  int     m_state = 0, m_cnt = 0, m_gd = 0, m_tk = 0;

  adsr_vca #(.TICK_DIV(TD), .ENV_W(16)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .WAVE         (WAVE),
    .GATE         (GATE),
    .ATTACK_STEP  (ATTACK_STEP),
    .DECAY_STEP   (DECAY_STEP),
    .SUSTAIN      (SUSTAIN),
    .RELEASE_STEP (RELEASE_STEP),
    .OUT          (OUT),
    .ENV          (ENV),
    .ACTIVE       (ACTIVE),
    .STATE        (STATE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: evaluate envelope rules on pre-edge inputs, advance, compare.
  task automatic cyc();
    longint n_env, n_out, a, d, s, r;
    int     n_state, n_cnt, tk, rise, fall;
    a = ATTACK_STEP; d = DECAY_STEP; s = SUSTAIN; r = RELEASE_STEP;
    tk    = (m_cnt == TD - 1);
    n_cnt = tk ? 0 : m_cnt + 1;
    rise  = (GATE && !m_gd);
    fall  = (!GATE && m_gd);
    n_out = (longint'(WAVE[31:16]) * m_env) / 65536;
    n_env = m_env;
    n_state = m_state;
    if (rise) n_state = 1;
    else if (fall && m_state >= 1 && m_state <= 3) n_state = 4;
    else begin
      case (m_state)
        1: if (tk) begin
             if (m_env + a >= 65535) begin n_env = 65535; n_state = 2; end
             else n_env = m_env + a;
           end
        2: if (tk) begin
             if (m_env - d <= s) begin n_env = s; n_state = 3; end
             else n_env = m_env - d;
           end
        3: n_env = s;
        4: if (tk) begin
             if (m_env <= r) begin n_env = 0; n_state = 0; end
             else n_env = m_env - r;
           end
        default: n_env = 0;
      endcase
    end
    if (RESET) begin
      n_env = 0; n_out = 0; n_state = 0; n_cnt = 0; m_gd = 0; tk = 0;
    end else begin
      m_gd = GATE ? 1 : 0;
    end
    @(posedge CLK);
    #1;
    m_env = n_env; m_out = n_out; m_state = n_state; m_cnt = n_cnt; m_tk = tk;
    chk("env",    32'(ENV),    32'(m_env));
    chk("state",  32'(STATE),  32'(m_state));
    chk("out",    32'(OUT),    32'(m_out));
    chk("active", 32'(ACTIVE), (m_state != 0) ? 32'd1 : 32'd0);
  endtask

  task automatic run_to_tick();
    int k = 0;
    do begin
      cyc();
      k++;
    end while (!m_tk && k < 3 * TD);
    if (!m_tk) chk("tick_wait", 32'd0, 32'd1);
  endtask

  task automatic run_to_state(input int st);
    int k = 0;
    while (m_state != st && k < 200) begin
      cyc();
      k++;
    end
    if (m_state != st) chk("state_wait", 32'(m_state), 32'(st));
  endtask

  initial begin
    longint e_hold;
    // reset
    RESET = 1'b1; GATE = 1'b0;
    repeat (5) cyc();
    chk("rst_out", 32'(OUT), 32'd0);
    chk("rst_env", 32'(ENV), 32'd0);
    chk("rst_state", 32'(STATE), 32'd0);
    chk("rst_active", 32'(ACTIVE), 32'd0);

    // attack
    RESET = 1'b0; GATE = 1'b1;
    ATTACK_STEP = 16'h4000; DECAY_STEP = 16'h1000;
    SUSTAIN = 16'hC000; RELEASE_STEP = 16'h3000; WAVE = 32'h8000_0000;
    cyc();
    chk("att_state", 32'(STATE), 32'd1);
    run_to_tick(); chk("att1", 32'(ENV), 32'h4000);
    run_to_tick(); chk("att2", 32'(ENV), 32'h8000);
    run_to_tick(); chk("att3", 32'(ENV), 32'hC000);
    run_to_tick(); chk("att4", 32'(ENV), 32'hFFFF);
    chk("att4_state", 32'(STATE), 32'd2);
    cyc(); chk("vca_full", 32'(OUT), 32'h7FFF);

    // decay and live sustain
    run_to_tick(); chk("dec1", 32'(ENV), 32'hEFFF);
    run_to_tick(); chk("dec2", 32'(ENV), 32'hDFFF);
    run_to_tick(); chk("dec3", 32'(ENV), 32'hCFFF);
    run_to_tick(); chk("dec4", 32'(ENV), 32'hC000);
    chk("dec4_state", 32'(STATE), 32'd3);
    SUSTAIN = 16'hA000; cyc(); chk("sus_track", 32'(ENV), 32'hA000);
    SUSTAIN = 16'hC000; cyc(); cyc(); chk("vca_c000", 32'(OUT), 32'h6000);

    // release to idle
    GATE = 1'b0; cyc(); chk("rel_state", 32'(STATE), 32'd4);
    run_to_tick(); chk("rel1", 32'(ENV), 32'h9000);
    run_to_tick(); chk("rel2", 32'(ENV), 32'h6000);
    run_to_tick(); chk("rel3", 32'(ENV), 32'h3000);
    run_to_tick(); chk("rel4", 32'(ENV), 32'h0);
    chk("rel_idle", 32'(STATE), 32'd0);
    chk("rel_inactive", 32'(ACTIVE), 32'd0);

    // legato retrigger from release
    GATE = 1'b1; cyc(); run_to_state(3);
    GATE = 1'b0; cyc();
    run_to_tick(); run_to_tick(); chk("rt_env", 32'(ENV), 32'h6000);
    GATE = 1'b1; cyc();
    chk("rt_state", 32'(STATE), 32'd1);
    chk("rt_hold", 32'(ENV), 32'h6000);
    run_to_tick(); chk("rt_step", 32'(ENV), 32'hA000);

    // rise coinciding with a tick applies no step
    GATE = 1'b0; cyc();
    begin
      int k = 0;
      while (m_cnt != TD - 1 && k < 2 * TD) begin cyc(); k++; end
    end
    e_hold = m_env;
    GATE = 1'b1; cyc();
    chk("rt_tick_state", 32'(STATE), 32'd1);
    chk("rt_tick_env", 32'(ENV), 32'(e_hold));

    // reset mid-attack
    cyc(); cyc();
    RESET = 1'b1; cyc();
    chk("mid_rst_env", 32'(ENV), 32'd0);
    chk("mid_rst_state", 32'(STATE), 32'd0);
    chk("mid_rst_out", 32'(OUT), 32'd0);
    chk("mid_rst_active", 32'(ACTIVE), 32'd0);
    RESET = 1'b0;

    // randomized traffic, model-checked every cycle
    for (int i = 0; i < 4000; i++) begin
      WAVE = $urandom;
      if ($urandom_range(0, 29) == 0) GATE = ~GATE;
      if ($urandom_range(0, 79) == 0) begin
        ATTACK_STEP  = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom);
        DECAY_STEP   = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom_range(0, 16'h3000));
        RELEASE_STEP = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom_range(0, 16'h3000));
        case ($urandom_range(0, 3))
          0:       SUSTAIN = 16'h0;
          1:       SUSTAIN = 16'hFFFF;
          default: SUSTAIN = 16'($urandom);
        endcase
      end
      RESET = ($urandom_range(0, 399) == 0);
      cyc();
    end
    RESET = 1'b0;

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/adsr_vca.md
# adsr_vca

Envelope generator and amplifier stage directly downstream of `form_wave`. It takes the 32-bit shaped waveform from `form_wave` and a note gate, and runs an attack/decay/sustain/release envelope at a prescaled tick rate. It outputs the waveform scaled by that envelope as a 16-bit unsigned sample for the DAC/mixer path.

## Interface
- `TICK_DIV`, default 1000: CLK cycles per envelope step; must be ≥ 2.
- `ENV_W`, default 16: envelope and output sample width.

- `CLK` in 1: system clock. One clock domain.
- `RESET` in 1: reset, synchronous and active-high.
- `WAVE` in 32: unsigned `DDSout` from `form_wave`. Only bits [31:16] are used.
- `GATE` in 1: note held. Level input, sampled every CLK.
- `ATTACK_STEP` in 16: envelope increment per tick in ATTACK.
- `DECAY_STEP` in 16: decrement per tick in DECAY.
- `SUSTAIN` in 16: sustain level.
- `RELEASE_STEP` in 16: decrement per tick in RELEASE.
- `OUT` out 16: amplified sample, registered.
- `ENV` out 16: current envelope level, registered.
- `ACTIVE` out 1: high when STATE ≠ IDLE.
- `STATE` out 3: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.

## Operation
- Gate edges: `GATE_d` is registered. `rise = GATE & ~GATE_d`; `fall = ~GATE & GATE_d`. Edges are evaluated every CLK, not only on ticks.
- Tick: counter runs 0..TICK_DIV-1. `tick` pulses when count = TICK_DIV-1. State changes never reset the counter.
- Step arithmetic uses 17 bits, then saturates and clamps. ENV never wraps.
- Transitions, evaluated in priority order:
  - `rise` (any state) → ATTACK. ENV keeps its current value (legato retrigger). No step is applied in this cycle, even if tick is also high.
  - `fall` in ATTACK, DECAY or SUSTAIN → RELEASE. No step is applied in this cycle.
  - ATTACK on tick: if ENV + ATTACK_STEP ≥ 0xFFFF, then ENV = 0xFFFF and go to DECAY. Otherwise ENV += ATTACK_STEP.
  - DECAY on tick: if ENV − DECAY_STEP ≤ SUSTAIN (signed compare, 17 bits), then ENV = SUSTAIN and go to SUSTAIN. Otherwise ENV −= DECAY_STEP.
  - SUSTAIN: ENV = SUSTAIN every CLK, so it tracks live changes.
  - RELEASE on tick: if ENV ≤ RELEASE_STEP, then ENV = 0 and go to IDLE. Otherwise ENV −= RELEASE_STEP.
  - IDLE: ENV = 0.
- Zero steps: a step of 0 holds ENV in that state indefinitely. This is legal.
- SUSTAIN = 0xFFFF: DECAY exits on its first tick.
- SUSTAIN = 0: the note decays to 0 and stays in SUSTAIN. It does not go to IDLE until after release.
- VCA: `OUT <= (WAVE[31:16] * ENV) >> 16`, using a 32-bit product and the upper half.

## Timing
- Reset state: OUT=0, ENV=0, STATE=IDLE, ACTIVE=0, tick counter=0, GATE_d=0.
- GATE high while RESET is high: a rise is seen on the first CLK after RESET deasserts.
- Reset mid-operation: returns to reset state on the next edge, regardless of state.
- ENV/STATE latency: ENV and STATE update on the CLK edge where the tick or edge is sampled.
- OUT latency: one cycle after ENV. OUT(n+1) is computed from WAVE(n) and ENV(n).
- Envelope timing: attack from 0 takes ceil(0xFFFF / ATTACK_STEP) ticks.
- Edge latency: GATE toggled at cycle n is seen at cycle n (combinational against GATE_d), so STATE changes at edge n+1.

## Structure
- Shared package `synth_pkg` holds:
  - the state localparams IDLE..RELEASE,
  - `ENV_MAX = 16'hFFFF`,
  - the `ENV_W` default.
- One sub-module, `env_tick`: parameterised prescaler with inputs CLK and RESET and output `tick`.
- The FSM, saturation logic and VCA multiply are in `adsr_vca`.
- The top-level synth instantiates this block after `form_wave`.

## Test plan
All scenarios use TICK_DIV=4.

1. **Reset:** hold RESET for 5 cycles with GATE=0 → OUT=0, ENV=0, STATE=0, ACTIVE=0.
2. **Attack:** GATE=1, ATTACK_STEP=0x4000 → ENV is 0x4000, 0x8000, 0xC000 on ticks 1–3. On tick 4, ENV=0xFFFF and STATE=DECAY.
3. **Decay:** DECAY_STEP=0x1000, SUSTAIN=0xC000 → ENV is 0xEFFF, 0xDFFF, 0xCFFF. On tick 4, ENV clamps to 0xC000 and STATE=SUSTAIN. Changing SUSTAIN to 0xA000 makes ENV=0xA000 on the next CLK.
4. **Release:** with ENV=0xC000, drop GATE and set RELEASE_STEP=0x3000 → STATE=RELEASE on the next edge. ENV is 0x9000, 0x6000, 0x3000, then 0. After that, STATE=IDLE and ACTIVE=0.
5. **VCA:** WAVE=0x8000_0000 → with ENV=0xFFFF, OUT=0x7FFF one cycle later. With ENV=0xC000, OUT=0x6000.
6. **Retrigger and reset:**
   - Re-raise GATE during RELEASE at ENV=0x6000 → STATE=ATTACK with ENV 0x6000 unchanged; the next tick gives 0xA000.
   - Raise GATE on the same cycle as a tick → no step is applied.
   - Assert RESET mid-ATTACK → the next cycle shows the full reset state.
